irrigation_sched: RTL

IRRIGATION_SCHED -- requirements
Module: irrigation_sched

---
 rtl/irrigation_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/irrigation_sched.sv
// Tank-fed irrigation controller: debounced level/heat sensing, a tank fill loop
// with a fill timeout, and a round-robin zone watering scheduler.
module irrigation_sched #(
  parameter int unsigned ZONES        = 4,
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned WATER_CYCLES = 16,
  parameter int unsigned REST_CYCLES  = 4,
  parameter int unsigned FILL_TIMEOUT = 64,
  localparam int unsigned ZW = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lvl_l,
  input  logic             lvl_m,
  input  logic             lvl_h,
  input  logic             hot,
  input  logic [ZONES-1:0] soil_dry,
  input  logic [ZONES-1:0] soil_wet,
  input  logic             fault_clr,
  output logic             fill_valve,
  output logic [ZONES-1:0] drip,
  output logic [ZONES-1:0] spray,
  output logic             alarm,
  output logic             error,
  output logic             fill_fault,
  output logic [ZW-1:0]    zone_idx,
  output logic [6:0]       seg
);

  localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned FW   = $clog2(FILL_TIMEOUT + 1);
  localparam int unsigned ZMAX = (WATER_CYCLES > REST_CYCLES) ? WATER_CYCLES : REST_CYCLES;
  localparam int unsigned CW   = $clog2(ZMAX + 1);

  typedef enum logic {F_IDLE = 1'b0, F_FILL = 1'b1} fill_state_t;
  typedef enum logic [1:0] {Z_SCAN = 2'd0, Z_WATER = 2'd1, Z_REST = 2'd2} zone_state_t;

  // Sensor filter: bit order {hot, h, m, l}
  logic [3:0]    raw_c;
  logic [3:0]    filt_q;
  logic [DW-1:0] deb_cnt_q [4];

  assign raw_c = {hot, lvl_h, lvl_m, lvl_l};

  // A differing raw value must persist DEB_CYCLES samples; returning to the filtered value restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raw_c[i] == filt_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          filt_q[i]    <= raw_c[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  logic l_c, m_c, h_c, hot_c;
  logic lvl_empty_c, lvl_low_c, lvl_high_c, err_c;

  assign l_c         = filt_q[0];
  assign m_c         = filt_q[1];
  assign h_c         = filt_q[2];
  assign hot_c       = filt_q[3];
  assign lvl_empty_c = ~l_c & ~m_c & ~h_c;
  assign lvl_low_c   =  l_c & ~m_c & ~h_c;
  assign lvl_high_c  =  l_c &  m_c &  h_c;
  assign err_c       = (~l_c & m_c) | (~m_c & h_c);

  // Fill FSM
  fill_state_t   fill_state, fill_nxt;
  logic [FW-1:0] fill_cnt, fill_cnt_nxt;
  logic          fault_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state <= F_IDLE;
      fill_cnt   <= '0;
      fill_fault <= 1'b0;
      fill_valve <= 1'b0;
    end else begin
      fill_state <= fill_nxt;
      fill_cnt   <= fill_cnt_nxt;
      fill_fault <= fault_nxt;
      fill_valve <= (fill_nxt == F_FILL);
    end
  end

  always_comb begin
    fill_nxt     = fill_state;
    fill_cnt_nxt = fill_cnt;
    fault_nxt    = fill_fault & ~fault_clr;
    case (fill_state)
      F_IDLE: begin
        if ((lvl_empty_c | lvl_low_c) & ~err_c & ~fill_fault) begin
          fill_nxt     = F_FILL;
          fill_cnt_nxt = '0;
        end
      end
      F_FILL: begin
        fill_cnt_nxt = fill_cnt + FW'(1);
        // Timeout is checked first so it overrides a coincident fault_clr.
        if (fill_cnt == FW'(FILL_TIMEOUT - 1)) begin
          fill_nxt     = F_IDLE;
          fill_cnt_nxt = '0;
          fault_nxt    = 1'b1;
        end else if (lvl_high_c | err_c) begin
          fill_nxt     = F_IDLE;
          fill_cnt_nxt = '0;
        end
      end
      default: fill_nxt = F_IDLE;
    endcase
  end

  // Zone scheduler FSM
  zone_state_t      zone_state, zone_nxt;
  logic [CW-1:0]    zone_cnt, zone_cnt_nxt;
  logic [ZW-1:0]    idx_nxt, idx_inc_c;
  logic [ZONES-1:0] zone_sel_c, drip_nxt, spray_nxt;
  logic             use_drip_c;

  assign idx_inc_c  = (zone_idx == ZW'(ZONES - 1)) ? '0 : zone_idx + ZW'(1);
  assign zone_sel_c = ZONES'(1) << zone_idx;
  assign use_drip_c = hot_c | lvl_low_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zone_state <= Z_SCAN;
      zone_cnt   <= '0;
      zone_idx   <= '0;
      drip       <= '0;
      spray      <= '0;
    end else begin
      zone_state <= zone_nxt;
      zone_cnt   <= zone_cnt_nxt;
      zone_idx   <= idx_nxt;
      drip       <= drip_nxt;
      spray      <= spray_nxt;
    end
  end

  always_comb begin
    zone_nxt     = zone_state;
    zone_cnt_nxt = zone_cnt;
    idx_nxt      = zone_idx;
    drip_nxt     = '0;
    spray_nxt    = '0;
    case (zone_state)
      Z_SCAN: begin
        if (soil_dry[zone_idx] & ~soil_wet[zone_idx] & ~lvl_empty_c & ~err_c) begin
          zone_nxt     = Z_WATER;
          zone_cnt_nxt = '0;
        end else begin
          idx_nxt = idx_inc_c;
        end
      end
      Z_WATER: begin
        if ((zone_cnt == CW'(WATER_CYCLES - 1)) | err_c | lvl_empty_c | soil_wet[zone_idx]) begin
          zone_nxt     = Z_REST;
          zone_cnt_nxt = '0;
        end else begin
          zone_cnt_nxt = zone_cnt + CW'(1);
        end
      end
      Z_REST: begin
        if (zone_cnt == CW'(REST_CYCLES - 1)) begin
          zone_nxt     = Z_SCAN;
          zone_cnt_nxt = '0;
          idx_nxt      = idx_inc_c;
        end else begin
          zone_cnt_nxt = zone_cnt + CW'(1);
        end
      end
      default: zone_nxt = Z_SCAN;
    endcase
    // The zone index never moves on a transition into or within WATER.
    if (zone_nxt == Z_WATER) begin
      drip_nxt  = use_drip_c ? zone_sel_c : '0;
      spray_nxt = use_drip_c ? '0 : zone_sel_c;
    end
  end

  // Status flags and level display; seg is {g,f,e,d,c,b,a}, active-low
  logic [6:0] seg_nxt;

  assign seg_nxt = err_c ? 7'h7F
                         : {~(l_c & m_c), 1'b1, 1'b1, ~l_c, 1'b1, 1'b1, ~(l_c & m_c & h_c)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
      alarm <= 1'b1;
      seg   <= 7'h7F;
    end else begin
      error <= err_c;
      alarm <= lvl_empty_c | lvl_low_c | err_c | fault_nxt;
      seg   <= seg_nxt;
    end
  end

endmodule
